// File: rtl/add16u_err_monitor.sv
`default_nettype none
// ============================================================================
// add16u_err_monitor : error statistics for an approximate WIDTH-bit adder
// Revision : 1.0
// ============================================================================
module add16u_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH:0]     in_o,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [WIDTH:0]     wce,
  output logic [WIDTH-1:0]   wce_a,
  output logic [WIDTH-1:0]   wce_b,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic               acc_sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic             w_accept;
  logic             w_clear;
  logic             w_last;

  logic             r_v1;
  logic [WIDTH:0]   r_exact;
  logic [WIDTH:0]   r_o1;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;

  logic             r_v2;
  logic [WIDTH:0]   r_abs;
  logic [WIDTH-1:0] r_a2;
  logic [WIDTH-1:0] r_b2;
  logic [WIDTH:0]   w_abs;
  logic [ACC_W:0]   w_acc_sum;

  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH:0]   r_wce;
  logic [WIDTH-1:0] r_wce_a;
  logic [WIDTH-1:0] r_wce_b;
  logic [ACC_W-1:0] r_sum;
  logic             r_sat;

  assign w_accept = in_valid & in_ready;
  assign w_clear  = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = w_accept & (r_remaining == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (run_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_v1 && !r_v2) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the state register only, so in_ready never sees in_valid.
  always_comb begin
    in_ready = (r_state == S_RUN);
    busy     = (r_state == S_RUN) | (r_state == S_DRAIN);
    done     = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
    end else if (w_clear) begin
      r_remaining <= run_len;
    end else if (w_accept) begin
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_exact <= '0;
      r_o1    <= '0;
      r_a1    <= '0;
      r_b1    <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_exact <= {1'b0, in_a} + {1'b0, in_b};
        r_o1    <= in_o;
        r_a1    <= in_a;
        r_b1    <= in_b;
      end
    end
  end

  assign w_abs = (r_exact >= r_o1) ? (r_exact - r_o1) : (r_o1 - r_exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_abs <= '0;
      r_a2  <= '0;
      r_b2  <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_abs <= w_abs;
        r_a2  <= r_a1;
        r_b2  <= r_b1;
      end
    end
  end

  // Extra MSB of the accumulator sum is the overflow flag for saturation.
  assign w_acc_sum = {1'b0, r_sum} + {{(ACC_W-WIDTH){1'b0}}, r_abs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_wce        <= '0;
      r_wce_a      <= '0;
      r_wce_b      <= '0;
      r_sum        <= '0;
      r_sat        <= 1'b0;
    end else if (w_clear) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_wce        <= '0;
      r_wce_a      <= '0;
      r_wce_b      <= '0;
      r_sum        <= '0;
      r_sat        <= 1'b0;
    end else if (r_v2) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      if (r_abs != '0) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (r_abs > r_wce) begin
        r_wce   <= r_abs;
        r_wce_a <= r_a2;
        r_wce_b <= r_b2;
      end
      if (w_acc_sum[ACC_W]) begin
        r_sum <= '1;
        r_sat <= 1'b1;
      end else begin
        r_sum <= w_acc_sum[ACC_W-1:0];
      end
    end
  end

  assign sample_cnt  = r_sample_cnt;
  assign err_cnt     = r_err_cnt;
  assign wce         = r_wce;
  assign wce_a       = r_wce_a;
  assign wce_b       = r_wce_b;
  assign sum_abs_err = r_sum;
  assign acc_sat     = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_add16u_err_monitor.sv
`default_nettype none
// ============================================================================
// tb_add16u_err_monitor : directed and random checks against a queue model
// Revision : 1.0
// ============================================================================
module tb_add16u_err_monitor;
  localparam int WIDTH = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int ACC_S = 18;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   run_len = '0;
  logic               in_valid = 1'b0;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic [WIDTH:0]     in_o = '0;

  logic               in_ready, busy, done, acc_sat;
  logic [CNT_W-1:0]   sample_cnt, err_cnt;
  logic [WIDTH:0]     wce;
  logic [WIDTH-1:0]   wce_a, wce_b;
  logic [ACC_W-1:0]   sum_abs_err;

  logic               s_in_ready, s_busy, s_done, s_acc_sat;
  logic [CNT_W-1:0]   s_sample_cnt, s_err_cnt;
  logic [WIDTH:0]     s_wce;
  logic [WIDTH-1:0]   s_wce_a, s_wce_b;
  logic [ACC_S-1:0]   s_sum_abs_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int a;
    int b;
    int o;
  } smp_t;

  smp_t m_q[$];
  int   m_rem = 0;

  add16u_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .wce(wce), .wce_a(wce_a), .wce_b(wce_b), .sum_abs_err(sum_abs_err), .acc_sat(acc_sat)
  );

  add16u_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
    .wce(s_wce), .wce_a(s_wce_a), .wce_b(s_wce_b), .sum_abs_err(s_sum_abs_err),
    .acc_sat(s_acc_sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_sample_cnt"}, sample_cnt, 0);
    check_val({tag, "_err_cnt"}, err_cnt, 0);
    check_val({tag, "_wce"}, wce, 0);
    check_val({tag, "_wce_a"}, wce_a, 0);
    check_val({tag, "_wce_b"}, wce_b, 0);
    check_val({tag, "_sum"}, sum_abs_err, 0);
    check_val({tag, "_acc_sat"}, acc_sat, 0);
  endtask

  // Called at a falling edge; start is seen by exactly one rising edge.
  task automatic do_start(input int len);
    start   = 1'b1;
    run_len = len;
    m_q.delete();
    m_rem = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one cycle; the model accepts whenever it still owes samples.
  task automatic send(input logic v, input int a, input int b, input int o);
    smp_t s;
    in_valid = v;
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_o     = o[WIDTH:0];
    check_val("in_ready", in_ready, (m_rem > 0) ? 64'd1 : 64'd0);
    if (v && m_rem > 0) begin
      s.a = a;
      s.b = b;
      s.o = o;
      m_q.push_back(s);
      m_rem--;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    longint cnt, ec, w, wa, wb, sum, lim, e;
    bit     sat;
    int     n;
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_busy"}, busy, 0);
    cnt = 0; ec = 0; w = 0; wa = 0; wb = 0; sum = 0; sat = 0;
    lim = (longint'(1) << ACC_W) - 1;
    foreach (m_q[i]) begin
      e = longint'(m_q[i].a) + longint'(m_q[i].b) - longint'(m_q[i].o);
      if (e < 0) e = -e;
      cnt++;
      if (e != 0) ec++;
      if (e > w) begin
        w  = e;
        wa = m_q[i].a;
        wb = m_q[i].b;
      end
      sum = sum + e;
      if (sum > lim) begin
        sum = lim;
        sat = 1;
      end
    end
    check_val({tag, "_sample_cnt"}, sample_cnt, cnt);
    check_val({tag, "_err_cnt"}, err_cnt, ec);
    check_val({tag, "_wce"}, wce, w);
    check_val({tag, "_wce_a"}, wce_a, wa);
    check_val({tag, "_wce_b"}, wce_b, wb);
    check_val({tag, "_sum"}, sum_abs_err, sum);
    check_val({tag, "_acc_sat"}, acc_sat, sat);
  endtask

  initial begin
    int len, a, b, o, guard;
    logic v;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(logic'(i % 2), 7, 9, 3);
    check_zero("idle");

    // Exact stream
    do_start(4);
    send(1, 1, 2, 3);
    send(1, 'hFFFF, 1, 'h10000);
    send(1, 0, 0, 0);
    send(1, 'h8000, 'h8000, 'h10000);
    finish_run("exact");

    // Error stream
    do_start(3);
    send(1, 'h100, 'h100, 'h0);
    send(1, 5, 5, 'h107);
    send(1, 'h100, 'h100, 'h300);
    finish_run("err");
    check_val("err_sum_const", sum_abs_err, 'h3FD);
    check_val("err_wce_const", wce, 'h200);

    // Start in DONE with a pending in_valid: stats cleared, sample dropped
    in_valid = 1'b1;
    start    = 1'b1;
    run_len  = 0;
    m_q.delete();
    m_rem = 0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    finish_run("restart0");

    // Tie handling and two-edge latency
    do_start(2);
    send(1, 1, 1, 0);
    check_val("lat_e0", sample_cnt, 0);
    send(0, 0, 0, 0);
    check_val("lat_e1", sample_cnt, 0);
    send(0, 0, 0, 0);
    check_val("lat_e2_cnt", sample_cnt, 1);
    check_val("lat_e2_wce", wce, 2);
    send(1, 2, 0, 4);
    finish_run("tie");
    check_val("tie_wce_a", wce_a, 1);

    // Gaps, ignored start in RUN, and a surplus in_valid after the last accept
    do_start(3);
    send(1, 10, 20, 31);
    start   = 1'b1;
    run_len = 0;
    send(0, 0, 0, 0);
    start = 1'b0;
    check_val("gap_busy", busy, 1);
    send(1, 'hFFFF, 'hFFFF, 0);
    send(0, 0, 0, 0);
    send(1, 3, 4, 7);
    send(1, 99, 99, 0);
    finish_run("gap");
    check_val("gap_cnt_const", sample_cnt, 3);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 24);
      do_start(len);
      guard = 0;
      while (m_rem > 0 && guard < 400) begin
        v = ($urandom_range(0, 9) < 7);
        a = $urandom_range(0, 1) ? 'hFFFF - $urandom_range(0, 3) : $urandom_range(0, 'hFFFF);
        b = $urandom_range(0, 'hFFFF);
        case ($urandom_range(0, 3))
          0: o = a + b;
          1: o = a + b + $urandom_range(0, 300);
          2: o = a + b - $urandom_range(0, 300);
          default: o = $urandom_range(0, 'h1FFFF);
        endcase
        if (o < 0) o = 0;
        if (o > 'h1FFFF) o = 'h1FFFF;
        send(v, a, b, o);
        guard++;
      end
      finish_run($sformatf("rnd%0d", r));
    end

    // Saturation on the narrow-accumulator instance
    do_start(3);
    for (int i = 0; i < 3; i++) send(1, 0, 0, 'h1FFFF);
    finish_run("sat_wide");
    check_val("sat_sum", s_sum_abs_err, 'h3FFFF);
    check_val("sat_flag", s_acc_sat, 1);
    check_val("sat_cnt", s_sample_cnt, 3);
    do_start(0);
    check_val("sat_clr_flag", s_acc_sat, 0);
    check_val("sat_clr_sum", s_sum_abs_err, 0);
    check_val("sat_clr_done", s_done, 1);

    // Asynchronous abort mid-run
    do_start(5);
    send(1, 1, 1, 9);
    send(1, 2, 2, 9);
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_rem = 0;
    check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
